core_control_fsm: RTL
=====================

Name: core_control_fsm

Overview:
Multi-cycle sequencer for the RV32I core. Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB. Drives the write enables and mux selects for the PC register, instruction register, register file, ALU operand muxes and the shared memory port. Sits between the decoder outputs (opcode, funct3) and the datapath. Arbitrates the single memory port between instruction fetch and load/store.

Parameters:
MEM_TIMEOUT, 255, maximum cycles a memory request may wait for mem_ready before bus-error trap; 0 disables the watchdog.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
opcode  input  7  opcode[6:0] from decoder (current IR)
branch_taken  input  1  branch comparison result from ALU, valid in EXECUTE
mem_ready  input  1  memory port completion strobe
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  1 = store access
mem_is_ifetch  output  1  1 = address mux selects PC, 0 = ALU result
ir_we  output  1  instruction register load enable
pc_we  output  1  PC register load enable
pc_sel  output  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = (rs1+imm)&~1 (JALR)
alu_a_sel  output  1  0 = rs1, 1 = PC
alu_b_sel  output  1  0 = rs2, 1 = imm
rf_we  output  1  register file write enable
wb_sel  output  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = imm (LUI)
state_out  output  3  current state encoding
halted  output  1  ECALL/EBREAK reached
illegal  output  1  illegal-opcode or bus-error trap
instret  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5, TRAP=6. The state register is the only sequential element besides the watchdog counter and instret.
- Outputs are combinational from state, opcode, branch_taken and mem_ready. Any output not listed for a state is 0.
- While reset=0: state=FETCH asynchronously, watchdog=0, instret=0, all outputs forced 0. The first mem_req=1 appears in the first cycle after reset rises. Reset mid-transaction abandons the access with no retire.
- FETCH: mem_req=1, mem_is_ifetch=1. If mem_ready=1: ir_we=1, next DECODE. Otherwise hold.
- DECODE: one cycle.
  - opcode 1110011 (SYSTEM) -> HALT.
  - Legal opcodes 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111 -> EXECUTE.
  - Any other opcode -> TRAP.
- EXECUTE:
  - Operand selects: alu_a_sel=1 for AUIPC/JAL/BRANCH target. alu_b_sel=1 for all except OP (0110011) and BRANCH compare.
  - BRANCH: pc_we=1, pc_sel=branch_taken?1:0, retire, next FETCH.
  - FENCE: pc_we=1, pc_sel=0, retire, next FETCH.
  - LOAD/STORE -> MEM. All others -> WB.
- MEM: mem_req=1, mem_is_ifetch=0, mem_we=1 for STORE. On mem_ready:
  - STORE: pc_we=1, pc_sel=0, retire, next FETCH.
  - LOAD: next WB.
- WB: rf_we=1, pc_we=1, retire, next FETCH.
  - wb_sel: LOAD=1, JAL/JALR=2, LUI=3, else 0.
  - pc_sel: JAL=1, JALR=2, else 0.
- HALT: halted=1, terminal until reset.
- TRAP: illegal=1, terminal until reset.
- Watchdog:
  - Counter clears on entry to FETCH or MEM and on mem_ready. It increments each cycle mem_req=1 and mem_ready=0.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0, next state is TRAP and the request drops.
  - mem_ready in the same cycle as the limit wins (normal progress).
  - The counter saturates and never wraps.
- mem_ready outside FETCH/MEM is ignored.
- Retire = the pc_we cycle in EXECUTE/MEM/WB. HALT and TRAP never retire.

Optional Feature:
Macro CORE_CTRL_INSTRET_EN.
- Defined: instret is a 32-bit counter incremented on each retire cycle. It wraps 0xFFFFFFFF -> 0 and resets to 0.
- Undefined: no counter is built and instret is tied to 32'h0.

Test Plan:
- Reset low mid-FETCH with mem_req=1 -> all outputs 0 immediately. Release reset -> state_out=0 and mem_req=1 next cycle.
- OP-IMM 0010011 with mem_ready after 2 wait cycles -> states 0,0,0,1,2,4,0. Exactly one cycle each of ir_we, rf_we (wb_sel=0) and pc_we (pc_sel=0). instret=1.
- LOAD 0000011, data access mem_ready after 3 cycles -> states 0,1,2,3,3,3,3,4,0. WB has wb_sel=1. STORE 0100011 -> mem_we=1 in MEM, no WB, pc_we on mem_ready.
- BRANCH with branch_taken=1 -> pc_sel=1 in EXECUTE. With branch_taken=0 -> pc_sel=0. JALR -> WB with wb_sel=2, pc_sel=2.
- Opcode 1111111 -> TRAP, illegal=1 held 100 cycles. ECALL 1110011 -> HALT, halted=1, instret unchanged.
- MEM_TIMEOUT=4 with mem_ready stuck 0 in FETCH -> TRAP after 4 waiting cycles, mem_req drops. Repeat with mem_ready on the 4th cycle -> DECODE, no trap.

Source files
------------

// File: rtl/core_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32I core with a memory watchdog.
// Define CORE_CTRL_INSTRET_EN to build the retired-instruction counter; otherwise instret reads 0.
module core_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_is_ifetch,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state_out,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] instret
);
    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;
    localparam logic [2:0] S_TRAP    = 3'd6;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int unsigned WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [2:0]      state, state_nx;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;
    logic            is_legal;
    logic            is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic            is_load, is_store, is_op, is_fence;

    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_op     = (opcode == OP_OP);
    assign is_fence  = (opcode == OP_FENCE);

    always_comb begin
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_FENCE: is_legal = 1'b1;
            default:                                      is_legal = 1'b0;
        endcase
    end

    // The limit cycle itself is the last chance: mem_ready there still wins.
    assign wd_expired = (MEM_TIMEOUT != 0) && (wd_cnt >= WD_LAST);

    always_comb begin
        state_nx      = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_is_ifetch = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = 2'd0;
        alu_a_sel     = 1'b0;
        alu_b_sel     = 1'b0;
        rf_we         = 1'b0;
        wb_sel        = 2'd0;
        halted        = 1'b0;
        illegal       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req       = 1'b1;
                mem_is_ifetch = 1'b1;
                if (mem_ready) begin
                    ir_we    = 1'b1;
                    state_nx = S_DECODE;
                end else if (wd_expired) begin
                    state_nx = S_TRAP;
                end
            end
            S_DECODE: begin
                if (opcode == OP_SYSTEM) state_nx = S_HALT;
                else if (is_legal)       state_nx = S_EXECUTE;
                else                     state_nx = S_TRAP;
            end
            S_EXECUTE: begin
                alu_a_sel = is_auipc | is_jal | is_branch;
                alu_b_sel = ~(is_op | is_branch);
                if (is_branch) begin
                    pc_we    = 1'b1;
                    pc_sel   = branch_taken ? 2'd1 : 2'd0;
                    state_nx = S_FETCH;
                end else if (is_fence) begin
                    pc_we    = 1'b1;
                    state_nx = S_FETCH;
                end else if (is_load || is_store) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_we    = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end else if (wd_expired) begin
                    state_nx = S_TRAP;
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                pc_we    = 1'b1;
                wb_sel   = is_load ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
                pc_sel   = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
                state_nx = S_FETCH;
            end
            S_HALT:  halted  = 1'b1;
            S_TRAP:  illegal = 1'b1;
            default: state_nx = S_TRAP;
        endcase
        // State is already FETCH during reset, so the outputs need explicit gating.
        if (!reset) begin
            mem_req       = 1'b0;
            mem_is_ifetch = 1'b0;
            ir_we         = 1'b0;
            pc_we         = 1'b0;
        end
    end

    assign state_out = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wd_cnt <= '0;
        else if (mem_ready || ((state_nx != state) && (state_nx == S_FETCH || state_nx == S_MEM)))
            wd_cnt <= '0;
        else if (mem_req && (wd_cnt != '1))
            wd_cnt <= wd_cnt + WD_W'(1);
    end

`ifdef CORE_CTRL_INSTRET_EN
    logic [31:0] instret_q;

    // Every retire is exactly one pc_we cycle; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     instret_q <= '0;
        else if (pc_we) instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule
